// File: rtl/prog_launcher.sv
// Host-side batch launcher for the core's Start/Done handshake; times each program run, Done-to-result latency 1 cycle.
// No backpressure: Go is ignored while Busy. Define PROG_LAUNCHER_TIMEOUT_EN to enable the RUN watchdog.
module prog_launcher #(
    parameter int          NUM_PROGS  = 3,
    parameter int          START_HOLD = 2,
    parameter int          CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 4096,
    localparam int         IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   Go,
    input  logic [8*NUM_PROGS-1:0] ProgAddr,
    input  logic                   Done,
    output logic                   Start,
    output logic [7:0]             StartAddr,
    output logic [IDX_W-1:0]       ProgIdx,
    output logic [CNT_W-1:0]       CycleCount,
    output logic                   CountValid,
    output logic                   Busy,
    output logic                   AllDone,
    output logic                   TimedOut
);

    localparam int HOLD_W = $clog2(START_HOLD + 1);
`ifdef PROG_LAUNCHER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, RECORD, FINISH} state_t;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [8*NUM_PROGS-1:0] addr_q, addr_d;
    logic                   start_q, start_d;
    logic [7:0]             start_addr_q, start_addr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       idx_nxt;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic                   count_valid_q, count_valid_d;
    logic                   busy_q, busy_d;
    logic                   all_done_q, all_done_d;
    logic                   timed_out_q, timed_out_d;

    assign idx_nxt = idx_q + IDX_W'(1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            start_q       <= 1'b1;
            start_addr_q  <= '0;
            idx_q         <= '0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            start_q       <= start_d;
            start_addr_q  <= start_addr_d;
            idx_q         <= idx_d;
            cycle_count_q <= cycle_count_d;
            count_valid_q <= count_valid_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
            timed_out_q   <= timed_out_d;
        end
    end

    // Outputs are computed for the state being entered, so every port is a flop.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        start_d       = start_q;
        start_addr_d  = start_addr_q;
        idx_d         = idx_q;
        cycle_count_d = cycle_count_q;
        count_valid_d = 1'b0;
        busy_d        = busy_q;
        all_done_d    = all_done_q;
        timed_out_d   = timed_out_q;
        case (state_q)
            IDLE, FINISH: begin
                if (Go) begin
                    state_d      = LAUNCH;
                    addr_d       = ProgAddr;
                    idx_d        = '0;
                    start_addr_d = ProgAddr[7:0];
                    start_d      = 1'b1;
                    busy_d       = 1'b1;
                    all_done_d   = 1'b0;
                    timed_out_d  = 1'b0;
                    hold_d       = '0;
                    cnt_d        = '0;
                end
            end
            LAUNCH: begin
                cnt_d = '0;
                if (hold_q == HOLD_W'(START_HOLD - 1)) begin
                    state_d = RUN;
                    start_d = 1'b0;
                    hold_d  = '0;
                    cnt_d   = CNT_W'(1);
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (Done) begin
                    state_d       = RECORD;
                    start_d       = 1'b1;
                    cycle_count_d = cnt_q;
                    count_valid_d = 1'b1;
                end else if (TIMEOUT_EN && (cnt_q == CNT_W'(TIMEOUT))) begin
                    state_d       = FINISH;
                    start_d       = 1'b1;
                    busy_d        = 1'b0;
                    all_done_d    = 1'b1;
                    timed_out_d   = 1'b1;
                    cycle_count_d = cnt_q;
                    count_valid_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECORD: begin
                if (idx_q == IDX_W'(NUM_PROGS - 1)) begin
                    state_d    = FINISH;
                    busy_d     = 1'b0;
                    all_done_d = 1'b1;
                end else begin
                    state_d      = LAUNCH;
                    idx_d        = idx_nxt;
                    start_addr_d = addr_q[8*int'(idx_nxt) +: 8];
                    hold_d       = '0;
                    cnt_d        = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Start      = start_q;
    assign StartAddr  = start_addr_q;
    assign ProgIdx    = idx_q;
    assign CycleCount = cycle_count_q;
    assign CountValid = count_valid_q;
    assign Busy       = busy_q;
    assign AllDone    = all_done_q;
    assign TimedOut   = timed_out_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Randomized bench for prog_launcher: expected per-cycle outputs come from the batch timeline
// (START_HOLD launch cycles, L run cycles, one record cycle per program).
module tb_prog_launcher;

    localparam int NP = 3;
    localparam int SH = 2;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            go_a, done_a, start_a, cv_a, busy_a, alld_a, to_a;
    logic [8*NP-1:0] paddr_a;
    logic [7:0]      saddr_a;
    logic [1:0]      idx_a;
    logic [15:0]     cc_a;

    logic            go_b, done_b, start_b, cv_b, busy_b, alld_b, to_b;
    logic [7:0]      paddr_b, saddr_b;
    logic [0:0]      idx_b;
    logic [15:0]     cc_b;

    prog_launcher #(.NUM_PROGS(NP), .START_HOLD(SH), .CNT_W(16), .TIMEOUT(TO)) u_dut_a (
        .CLK(clk), .Reset(rst), .Go(go_a), .ProgAddr(paddr_a), .Done(done_a),
        .Start(start_a), .StartAddr(saddr_a), .ProgIdx(idx_a), .CycleCount(cc_a),
        .CountValid(cv_a), .Busy(busy_a), .AllDone(alld_a), .TimedOut(to_a)
    );

    prog_launcher #(.NUM_PROGS(1), .START_HOLD(SH), .CNT_W(16), .TIMEOUT(4096)) u_dut_b (
        .CLK(clk), .Reset(rst), .Go(go_b), .ProgAddr(paddr_b), .Done(done_b),
        .Start(start_b), .StartAddr(saddr_b), .ProgIdx(idx_b), .CycleCount(cc_b),
        .CountValid(cv_b), .Busy(busy_b), .AllDone(alld_b), .TimedOut(to_b)
    );

    logic [7:0] addr_m [NP];
    int         len_m  [NP];   // run length per program; 0 means Done never comes
    int         exp_cc, exp_idx, exp_to;
    int         n_chk = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle_chk(input string tag, input logic s, input logic b, input logic ad, input logic v);
        check_eq({tag, ".Start"},      32'(start_a), 32'(s));
        check_eq({tag, ".Busy"},       32'(busy_a),  32'(b));
        check_eq({tag, ".AllDone"},    32'(alld_a),  32'(ad));
        check_eq({tag, ".CountValid"}, 32'(cv_a),    32'(v));
        check_eq({tag, ".CycleCount"}, 32'(cc_a),    exp_cc);
        check_eq({tag, ".ProgIdx"},    32'(idx_a),   exp_idx);
        check_eq({tag, ".TimedOut"},   32'(to_a),    exp_to);
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        go_a   = 1'b0;
        done_a = 1'b0;
        #1;
        exp_cc  = 0;
        exp_idx = 0;
        exp_to  = 0;
        cycle_chk("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst.StartAddr", 32'(saddr_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cycle_chk("idle", 1'b1, 1'b0, 1'b0, 1'b0);
            done_a = 1'b1;
        end
        done_a = 1'b0;
    endtask

    // Runs one batch of NP programs on DUT A; rst_cyc>0 resets during that RUN cycle of program 1.
    task automatic run_batch(input int rst_cyc);
        logic [8*NP-1:0] packed_addr;
        bit              timed;
        int              c;
        for (int i = 0; i < NP; i++) packed_addr[8*i +: 8] = addr_m[i];
        paddr_a = packed_addr;
        go_a    = 1'b1;
        done_a  = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_idx = 0;
        exp_to  = 0;
        timed   = 1'b0;
        for (int p = 0; p < NP && !timed; p++) begin
            exp_idx = p;
            for (int h = 0; h < SH; h++) begin
                cycle_chk("launch", 1'b1, 1'b1, 1'b0, 1'b0);
                check_eq("launch.StartAddr", 32'(saddr_a), 32'(addr_m[p]));
                go_a    = ($urandom_range(0, 3) == 0);
                paddr_a = 24'($urandom);
                done_a  = (len_m[p] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            c = 0;
            forever begin
                c++;
                cycle_chk("run", 1'b0, 1'b1, 1'b0, 1'b0);
                if (p == 1 && c == rst_cyc) begin
                    apply_reset();
                    return;
                end
                done_a  = (c == len_m[p]);
                go_a    = ($urandom_range(0, 7) == 0);
                paddr_a = 24'($urandom);
                @(negedge clk);
                if (c == len_m[p]) break;
`ifdef PROG_LAUNCHER_TIMEOUT_EN
                if (c == TO) begin
                    timed = 1'b1;
                    break;
                end
`endif
            end
            if (timed) begin
                exp_cc = TO;
                exp_to = 1;
                cycle_chk("timeout", 1'b1, 1'b0, 1'b1, 1'b1);
            end else begin
                exp_cc = len_m[p];
                cycle_chk("record", 1'b1, 1'b1, 1'b0, 1'b1);
            end
            go_a   = !timed;
            done_a = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        go_a = 1'b0;
        repeat (3) begin
            cycle_chk("finish", 1'b1, 1'b0, 1'b1, 1'b0);
            done_a  = 1'($urandom_range(0, 1));
            paddr_a = 24'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic single_prog();
        paddr_b = 8'h10;
        go_b    = 1'b1;
        done_b  = 1'b1;
        @(negedge clk);
        go_b    = 1'b0;
        paddr_b = 8'hEE;
        for (int h = 0; h < SH; h++) begin
            check_eq("single.launch.Start", 32'(start_b), 32'd1);
            check_eq("single.launch.StartAddr", 32'(saddr_b), 32'h10);
            check_eq("single.launch.Busy", 32'(busy_b), 32'd1);
            @(negedge clk);
        end
        for (int c = 1; c <= 10; c++) begin
            check_eq("single.run.Start", 32'(start_b), 32'd0);
            done_b = (c == 10);
            @(negedge clk);
        end
        done_b = 1'b0;
        check_eq("single.record.CountValid", 32'(cv_b), 32'd1);
        check_eq("single.record.CycleCount", 32'(cc_b), 32'd10);
        check_eq("single.record.ProgIdx", 32'(idx_b), 32'd0);
        check_eq("single.record.AllDone", 32'(alld_b), 32'd0);
        @(negedge clk);
        check_eq("single.finish.AllDone", 32'(alld_b), 32'd1);
        check_eq("single.finish.Busy", 32'(busy_b), 32'd0);
        check_eq("single.finish.CountValid", 32'(cv_b), 32'd0);
        check_eq("single.finish.TimedOut", 32'(to_b), 32'd0);
    endtask

    task automatic randomize_batch();
        for (int i = 0; i < NP; i++) begin
            addr_m[i] = 8'($urandom);
            len_m[i]  = $urandom_range(1, 12);
        end
    endtask

    initial begin
        rst     = 1'b1;
        go_a    = 1'b0;
        done_a  = 1'b0;
        paddr_a = '0;
        go_b    = 1'b0;
        done_b  = 1'b0;
        paddr_b = '0;
        exp_cc  = 0;
        exp_idx = 0;
        exp_to  = 0;
        repeat (2) @(negedge clk);
        cycle_chk("por", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("por.StartAddr", 32'(saddr_a), 32'd0);
        check_eq("por.B.Start", 32'(start_b), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        single_prog();

        addr_m = '{8'h00, 8'h20, 8'h40};
        len_m  = '{5, 7, 3};
        run_batch(0);

        for (int b = 0; b < 6; b++) begin
            randomize_batch();
            if (b == 1) len_m[0] = 1;
            if (b == 3) len_m[2] = 1;
            run_batch(0);
        end

        randomize_batch();
        len_m[1] = 10;
        run_batch(3);

        randomize_batch();
        run_batch(0);

`ifdef PROG_LAUNCHER_TIMEOUT_EN
        randomize_batch();
        len_m = '{4, 0, 5};
        run_batch(0);
`else
        randomize_batch();
        len_m = '{2, 3, 30};
        run_batch(0);
`endif

        randomize_batch();
        run_batch(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
